// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution line buffer: pixel width,
// sequencer states and the band/scan counts derived from image geometry.
package conv_pkg;

    localparam int PIX_W = 8;

    localparam int DEF_IMAGE_WIDTH  = 128;
    localparam int DEF_IMAGE_HEIGHT = 128;
    localparam int DEF_FILTER_SIZE  = 3;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PRIME,
        SCAN,
        WAIT_ACK,
        ROLL,
        LOAD,
        DONE
    } state_t;

    // Number of vertical filter positions per frame.
    function automatic int n_bands(input int image_height, input int filter_size);
        return image_height - filter_size + 1;
    endfunction

    // Number of horizontal filter positions per band.
    function automatic int scan_len(input int image_width, input int filter_size);
        return image_width - filter_size + 1;
    endfunction

    localparam int N_BANDS  = n_bands(DEF_IMAGE_HEIGHT, DEF_FILTER_SIZE);
    localparam int SCAN_LEN = scan_len(DEF_IMAGE_WIDTH, DEF_FILTER_SIZE);

endpackage

// File: rtl/linebuf_row_store.sv
// FILTER_SIZE x IMAGE_WIDTH pixel store with single-pixel write and a
// one-row roll-up (row r takes row r+1, bottom row kept).
module linebuf_row_store
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH = 128,
    parameter int FILTER_SIZE = 3,
    parameter int ROW_W       = $clog2(FILTER_SIZE) + 1,
    parameter int COL_W       = $clog2(IMAGE_WIDTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [ROW_W-1:0]                       wr_row,
    input  logic [COL_W-1:0]                       wr_col,
    input  logic [PIX_W-1:0]                       wr_data,
    input  logic                                   roll,
    output logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] rows
);

    // NOTE: this store is built from flops, not a RAM macro, so it can and
    // must be cleared by reset; a RAM-inferred array could not be.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rows <= '0;
        end else begin
            for (int r = 0; r < FILTER_SIZE; r++) begin
                for (int c = 0; c < IMAGE_WIDTH; c++) begin
                    if (roll && (r < FILTER_SIZE - 1)) begin
                        rows[(r*IMAGE_WIDTH + c)*PIX_W +: PIX_W] <=
                            rows[(((r < FILTER_SIZE - 1) ? r + 1 : r)*IMAGE_WIDTH + c)*PIX_W +: PIX_W];
                    end else if (!roll && wr_en && (int'(wr_row) == r) && (int'(wr_col) == c)) begin
                        rows[(r*IMAGE_WIDTH + c)*PIX_W +: PIX_W] <= wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_line_buffer.sv
// Line buffer and band sequencer feeding the window-shift stage.
// Optional stall counter output enabled by defining LINEBUF_STALL_CNT_EN.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int FILTER_SIZE  = DEF_FILTER_SIZE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     pix_valid,
    input  logic [PIX_W-1:0]                         pix_data,
    output logic                                     pix_ready,
    output logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] row_buffer_out,
    output logic                                     shift_en,
    output logic                                     shift_buffer,
    input  logic                                     new_buffer,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]          band_idx,
    output logic                                     busy,
    output logic                                     frame_done
`ifdef LINEBUF_STALL_CNT_EN
    ,
    output logic [15:0]                              stall_cnt
`endif
);

    localparam int SCAN_N = scan_len(IMAGE_WIDTH, FILTER_SIZE);
    localparam int BANDS  = n_bands(IMAGE_HEIGHT, FILTER_SIZE);
    localparam int COL_W  = $clog2(IMAGE_WIDTH) + 1;
    localparam int ROW_W  = $clog2(FILTER_SIZE) + 1;
    localparam int SCAN_W = $clog2(SCAN_N) + 1;
    localparam int BAND_W = $clog2(IMAGE_HEIGHT);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(FILTER_SIZE - 1);
    localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(SCAN_N - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BANDS - 1);

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [SCAN_W-1:0] scan_cnt;

    logic              xfer;
    logic [ROW_W-1:0]  wr_row;
    logic              roll;

    assign xfer   = pix_valid && pix_ready;
    assign wr_row = (state == LOAD) ? LAST_ROW : row;
    assign roll   = (state == ROLL);

    linebuf_row_store #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .FILTER_SIZE (FILTER_SIZE),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (xfer),
        .wr_row  (wr_row),
        .wr_col  (col),
        .wr_data (pix_data),
        .roll    (roll),
        .rows    (row_buffer_out)
    );

    // NOTE: every register below is updated with <= so that all of them see
    // the pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            scan_cnt     <= '0;
            band_idx     <= '0;
            pix_ready    <= 1'b0;
            shift_en     <= 1'b0;
            shift_buffer <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        col       <= '0;
                        row       <= '0;
                        band_idx  <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= FILL;
                    end
                end

                FILL: begin
                    if (xfer) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == LAST_ROW) begin
                                pix_ready <= 1'b0;
                                shift_en  <= 1'b1;
                                state     <= PRIME;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                PRIME: begin
                    shift_en     <= 1'b0;
                    shift_buffer <= 1'b1;
                    scan_cnt     <= '0;
                    state        <= SCAN;
                end

                SCAN: begin
                    if (scan_cnt == LAST_SCAN) begin
                        shift_buffer <= 1'b0;
                        state        <= WAIT_ACK;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end

                WAIT_ACK: begin
                    if (new_buffer) begin
                        if (band_idx == LAST_BAND) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            band_idx <= band_idx + 1'b1;
                            state    <= ROLL;
                        end
                    end
                end

                ROLL: begin
                    col       <= '0;
                    pix_ready <= 1'b1;
                    state     <= LOAD;
                end

                LOAD: begin
                    if (xfer) begin
                        if (col == LAST_COL) begin
                            col       <= '0;
                            pix_ready <= 1'b0;
                            shift_en  <= 1'b1;
                            state     <= PRIME;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINEBUF_STALL_CNT_EN
    // Upstream starvation: cycles where a pixel could be taken but none is offered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if ((state == FILL || state == LOAD) && !pix_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer at 8x6 image, 3-row filter;
// pixel value = 8*row + col.
module tb_conv_line_buffer;
    import conv_pkg::*;

    localparam int W      = 8;
    localparam int H      = 6;
    localparam int F      = 3;
    localparam int SCAN_N = W - F + 1;
    localparam int BW     = F * W * PIX_W;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          start      = 1'b0;
    logic          pix_valid  = 1'b0;
    logic [7:0]    pix_data   = 8'h00;
    logic          new_buffer = 1'b0;
    logic          pix_ready;
    logic [BW-1:0] row_buffer_out;
    logic          shift_en;
    logic          shift_buffer;
    logic [2:0]    band_idx;
    logic          busy;
    logic          frame_done;
`ifdef LINEBUF_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    int mon_xfer = 0, mon_se = 0, mon_sb = 0, mon_fd = 0, mon_overlap = 0;
    int c0, sb0, x0, se0, fd0;

    always #5 clk = ~clk;

    conv_line_buffer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .FILTER_SIZE  (F)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .row_buffer_out (row_buffer_out),
        .shift_en       (shift_en),
        .shift_buffer   (shift_buffer),
        .new_buffer     (new_buffer),
        .band_idx       (band_idx),
        .busy           (busy),
        .frame_done     (frame_done)
`ifdef LINEBUF_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always @(negedge clk) begin
        if (pix_valid && pix_ready) mon_xfer++;
        if (shift_en) mon_se++;
        if (shift_buffer) mon_sb++;
        if (frame_done) mon_fd++;
        if (shift_en && shift_buffer) mon_overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic logic [BW-1:0] exp_rows(input int top);
        logic [BW-1:0] v;
        v = '0;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < W; c++)
                v[(r*W + c)*8 +: 8] = 8'(8*(top + r) + c);
        return v;
    endfunction

    // Offers one image row; with gaps, pix_valid drops for one cycle before odd columns.
    task automatic send_row(input int img_row, input bit gaps);
        int budget;
        for (int c = 0; c < W; c++) begin
            if (gaps && (c % 2 == 1)) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = 8'(8*img_row + c);
            budget    = 0;
            while (!pix_ready && budget < 50) begin
                tick();
                budget++;
            end
            if (!pix_ready) check("pix_ready_timeout", BW'(pix_ready), BW'(1));
            tick();
        end
        pix_valid = 1'b0;
    endtask

    // Entered in PRIME; leaves the DUT in WAIT_ACK.
    task automatic run_scan(input int b, input bit poke_start);
        int n;
        n = 0;
        check($sformatf("prime_b%0d", b), BW'(shift_en), BW'(1));
        check($sformatf("band_idx_b%0d", b), BW'(band_idx), BW'(b));
        tick();
        while (shift_buffer && n < 100) begin
            start = (poke_start && n == 2);
            n++;
            tick();
        end
        start = 1'b0;
        check($sformatf("scan_len_b%0d", b), BW'(n), BW'(SCAN_N));
    endtask

    task automatic ack();
        tick();
        check("wait_ack_sb_low", BW'(shift_buffer), BW'(0));
        check("wait_ack_busy", BW'(busy), BW'(1));
        new_buffer = 1'b1;
        tick();
        new_buffer = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_pix_ready", BW'(pix_ready), BW'(0));
        check("rst_shift_en", BW'(shift_en), BW'(0));
        check("rst_shift_buffer", BW'(shift_buffer), BW'(0));
        check("rst_busy", BW'(busy), BW'(0));
        check("rst_frame_done", BW'(frame_done), BW'(0));
        check("rst_band_idx", BW'(band_idx), BW'(0));
        check("rst_rows", row_buffer_out, BW'(0));
`ifdef LINEBUF_STALL_CNT_EN
        check("rst_stall_cnt", BW'(stall_cnt), BW'(0));
`endif
        rst = 1'b1;
        tick();
        check("idle_busy", BW'(busy), BW'(0));

        // Frame A: fill with new_buffer forced during row 0, start poked during scan
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fill_pix_ready", BW'(pix_ready), BW'(1));
        check("fill_busy", BW'(busy), BW'(1));
        c0 = cycle;
        new_buffer = 1'b1;
        send_row(0, 1'b0);
        new_buffer = 1'b0;
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        check("fill_cycles", BW'(cycle - c0), BW'(24));
        check("prime_pix_ready", BW'(pix_ready), BW'(0));
        run_scan(0, 1'b1);
        check("rows_band0", row_buffer_out, exp_rows(0));
        ack();
        check("roll_band_idx", BW'(band_idx), BW'(1));
        tick();
        check("load_pix_ready", BW'(pix_ready), BW'(1));

        // Band 1 load with pix_valid toggling
        sb0 = mon_sb;
`ifdef LINEBUF_STALL_CNT_EN
        stall0 = stall_cnt;
`endif
        send_row(3, 1'b1);
        check("load_no_shift", BW'(mon_sb - sb0), BW'(0));
        check("rows_band1", row_buffer_out, exp_rows(1));
        check("row0_after_roll", BW'(row_buffer_out[63:0]), BW'(64'h0f0e0d0c0b0a0908));
`ifdef LINEBUF_STALL_CNT_EN
        check("stall_delta", BW'(16'(stall_cnt - stall0)), BW'(4));
`endif
        run_scan(1, 1'b0);
        ack();
        tick();
        send_row(4, 1'b0);

        // Band 2: abort with reset mid-scan
        check("prime_b2", BW'(shift_en), BW'(1));
        check("band_idx_b2", BW'(band_idx), BW'(2));
        fd0 = mon_fd;
        tick();
        tick();
        check("scan_b2_active", BW'(shift_buffer), BW'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_busy", BW'(busy), BW'(0));
        check("abort_pix_ready", BW'(pix_ready), BW'(0));
        check("abort_shift_buffer", BW'(shift_buffer), BW'(0));
        check("abort_shift_en", BW'(shift_en), BW'(0));
        check("abort_band_idx", BW'(band_idx), BW'(0));
        check("abort_rows", row_buffer_out, BW'(0));
        tick();
        tick();
        check("abort_no_frame_done", BW'(mon_fd - fd0), BW'(0));
        check("abort_stays_idle", BW'(busy), BW'(0));

        // Frame B: clean full frame
        x0  = mon_xfer;
        se0 = mon_se;
        fd0 = mon_fd;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_row(0, 1'b0);
        send_row(1, 1'b0);
        send_row(2, 1'b0);
        for (int b = 0; b < H - F + 1; b++) begin
            run_scan(b, 1'b0);
            check($sformatf("rows_frame_b%0d", b), row_buffer_out, exp_rows(b));
            ack();
            if (b < H - F) begin
                tick();
                send_row(b + F, 1'b0);
            end
        end
        check("frame_done_pulse", BW'(frame_done), BW'(1));
        tick();
        check("frame_done_cleared", BW'(frame_done), BW'(0));
        check("end_busy", BW'(busy), BW'(0));
        check("frame_pixels", BW'(mon_xfer - x0), BW'(W * H));
        check("frame_shift_en_pulses", BW'(mon_se - se0), BW'(4));
        check("frame_done_count", BW'(mon_fd - fd0), BW'(1));
        check("shift_overlap", BW'(mon_overlap), BW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
